// File: rtl/riscv_nn_apu_wb_buffer.sv
// APU write-back buffer: in-order FIFO feeding register-file port B with RAW hazard detection.
// Define APU_WB_BYPASS_EN to let a response go straight to port B when the buffer is empty and free.
module riscv_nn_apu_wb_buffer #(
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned FLAGS_WIDTH = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     apu_valid_i,
   output logic                     apu_ready_o,
   input  logic [5:0]               apu_waddr_i,
   input  logic [DATA_WIDTH-1:0]    apu_result_i,
   input  logic [FLAGS_WIDTH-1:0]   apu_flags_i,
   input  logic                     wport_busy_i,
   output logic                     rf_we_o,
   output logic [5:0]               rf_waddr_o,
   output logic [DATA_WIDTH-1:0]    rf_wdata_o,
   output logic                     flags_valid_o,
   output logic [FLAGS_WIDTH-1:0]   flags_o,
   input  logic [17:0]              read_regs_i,
   input  logic [2:0]               read_regs_valid_i,
   output logic                     read_dep_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [5:0]             waddr_q [DEPTH];
   logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
   logic [FLAGS_WIDTH-1:0] flags_q [DEPTH];
   logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]        count_q;

   logic push, pop, bypass;

   assign count_o     = count_q;
   assign full_o      = (count_q == CntW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign apu_ready_o = ~full_o | ~wport_busy_i;
   assign pop         = ~wport_busy_i & ~empty_o;

`ifdef APU_WB_BYPASS_EN
   assign bypass = empty_o & ~wport_busy_i & apu_valid_i;
`else
   assign bypass = 1'b0;
`endif

   assign push = apu_valid_i & apu_ready_o & ~bypass;

   // The head has priority over a bypass; both cannot occur since bypass requires empty.
   always_comb begin
      rf_we_o       = 1'b0;
      flags_valid_o = 1'b0;
      rf_waddr_o    = '0;
      rf_wdata_o    = '0;
      flags_o       = '0;
      if (pop) begin
         rf_we_o       = 1'b1;
         flags_valid_o = 1'b1;
         rf_waddr_o    = waddr_q[rd_ptr_q];
         rf_wdata_o    = data_q[rd_ptr_q];
         flags_o       = flags_q[rd_ptr_q];
      end else if (bypass) begin
         rf_we_o       = 1'b1;
         flags_valid_o = 1'b1;
         rf_waddr_o    = apu_waddr_i;
         rf_wdata_o    = apu_result_i;
         flags_o       = apu_flags_i;
      end
   end

   // An entry written this cycle is forwarded by the register file, so it raises no hazard.
   always_comb begin
      read_dep_o = 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
         if (read_regs_valid_i[r] && (read_regs_i[6*r +: 6] != 6'd0)) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
               if ((CntW'(e) < count_q) && !((e == 0) && pop) &&
                   (waddr_q[rd_ptr_q + PtrW'(e)] == read_regs_i[6*r +: 6])) begin
                  read_dep_o = 1'b1;
               end
            end
            if (apu_valid_i && !bypass && (apu_waddr_i == read_regs_i[6*r +: 6])) begin
               read_dep_o = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only observed while counted as valid.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push) begin
         waddr_q[wr_ptr_q] <= apu_waddr_i;
         data_q[wr_ptr_q]  <= apu_result_i;
         flags_q[wr_ptr_q] <= apu_flags_i;
      end
   end

endmodule

// File: tb/tb_riscv_nn_apu_wb_buffer.sv
// Scoreboard bench for riscv_nn_apu_wb_buffer against a queue-based model of the buffer.
module tb_riscv_nn_apu_wb_buffer;

   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
      logic [4:0]  f;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        apu_valid = 1'b0;
   logic        apu_ready;
   logic [5:0]  apu_waddr = '0;
   logic [31:0] apu_result = '0;
   logic [4:0]  apu_flags = '0;
   logic        wport_busy = 1'b1;
   logic        rf_we;
   logic [5:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        flags_valid;
   logic [4:0]  flags;
   logic [17:0] read_regs = '0;
   logic [2:0]  read_regs_valid = '0;
   logic        read_dep;
   logic [1:0]  count;
   logic        full, empty;

   int checks = 0;
   int failures = 0;

   ent_t mq[$];   // model of buffered entries, oldest first
   ent_t sb[$];   // accepted responses not yet seen written

   always #5 clk = ~clk;

   riscv_nn_apu_wb_buffer #(
      .DEPTH(DEPTH), .DATA_WIDTH(32), .FLAGS_WIDTH(5)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .apu_valid_i(apu_valid), .apu_ready_o(apu_ready), .apu_waddr_i(apu_waddr),
      .apu_result_i(apu_result), .apu_flags_i(apu_flags), .wport_busy_i(wport_busy),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .flags_valid_o(flags_valid), .flags_o(flags),
      .read_regs_i(read_regs), .read_regs_valid_i(read_regs_valid), .read_dep_o(read_dep),
      .count_o(count), .full_o(full), .empty_o(empty)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; apu_valid = 1'b0; wport_busy = 1'b1; read_regs_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      sb.delete();
   endtask

   // One clock of stimulus; returns whether the response was accepted.
   task automatic cycle(input logic v, input logic [5:0] a, input logic [31:0] d,
                        input logic [4:0] f, input logic b, input logic [17:0] rr,
                        input logic [2:0] rv, output logic acc);
      ent_t e;
      logic mready, byp, pop, dep;
      logic [5:0] rs;
      @(negedge clk);
      apu_valid = v; apu_waddr = a; apu_result = d; apu_flags = f;
      wport_busy = b; read_regs = rr; read_regs_valid = rv;
      #1;
      pop    = !b && (mq.size() != 0);
      mready = (mq.size() < DEPTH) || !b;
`ifdef APU_WB_BYPASS_EN
      byp = v && !b && (mq.size() == 0);
`else
      byp = 1'b0;
`endif
      acc = v && mready;
      dep = 1'b0;
      for (int r = 0; r < 3; r++) begin
         rs = rr[6*r +: 6];
         if (rv[r] && rs != 6'd0) begin
            for (int k = 0; k < mq.size(); k++)
               if (!(k == 0 && pop) && mq[k].a == rs) dep = 1'b1;
            if (v && !byp && a == rs) dep = 1'b1;
         end
      end
      chk("apu_ready", 64'(apu_ready), 64'(mready));
      chk("count", 64'(count), 64'(mq.size()));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("rf_we", 64'(rf_we), 64'(pop || byp));
      chk("read_dep", 64'(read_dep), 64'(dep));
      e.a = a; e.d = d; e.f = f;
      if (acc) sb.push_back(e);
      if (pop) void'(mq.pop_front());
      if (acc && !byp) mq.push_back(e);
   endtask

   // Monitor: every port-B write must match the oldest outstanding accepted response.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n === 1'b1) begin
            chk("flags_valid", 64'(flags_valid), 64'(rf_we));
            if (rf_we === 1'b1) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL stray_write: got write to %0d expected none at %0t",
                           rf_waddr, $time);
               end else begin
                  e = sb.pop_front();
                  chk("wr_addr", 64'(rf_waddr), 64'(e.a));
                  chk("wr_data", 64'(rf_wdata), 64'(e.d));
                  chk("wr_flags", 64'(flags), 64'(e.f));
               end
            end
         end
      end
   end

   initial begin
      logic acc;
      logic pv;
      logic [5:0] pa;
      logic [31:0] pd;
      logic [4:0] pf;
      do_reset();

      // Single result on a free port
      cycle(1, 6'd5, 32'hA5A5A5A5, 5'h01, 0, '0, '0, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);

      // Back-pressure, then full with simultaneous push and pop
      cycle(1, 6'd3, 32'h33, 5'h03, 1, '0, '0, acc);
      cycle(1, 6'd4, 32'h44, 5'h04, 1, '0, '0, acc);
      cycle(1, 6'd7, 32'h77, 5'h07, 1, '0, '0, acc);
      chk("held_third", 64'(acc), 64'(0));
      cycle(1, 6'd7, 32'h77, 5'h07, 0, '0, '0, acc);
      chk("full_accept", 64'(acc), 64'(1));
      cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);

      // Hazard against buffered register 9
      cycle(1, 6'd9, 32'h99, 5'h09, 1, '0, '0, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 1, {6'd0, 6'd9, 6'd0}, 3'b010, acc);
      chk("dep_on_9", 64'(read_dep), 64'(1));
      cycle(0, 6'd0, 32'h0, 5'h0, 1, {6'd0, 6'd0, 6'd0}, 3'b010, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 0, {6'd0, 6'd9, 6'd0}, 3'b010, acc);
      cycle(0, 6'd0, 32'h0, 5'h0, 0, {6'd0, 6'd9, 6'd0}, 3'b010, acc);

      // Reset with two entries buffered
      cycle(1, 6'd11, 32'hB1, 5'h0B, 1, '0, '0, acc);
      cycle(1, 6'd12, 32'hC2, 5'h0C, 1, '0, '0, acc);
      do_reset();
      for (int i = 0; i < 3; i++) cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);

      // Randomized traffic; an unaccepted response is held until taken
      pv = 0; pa = '0; pd = '0; pf = '0;
      for (int i = 0; i < 2000; i++) begin
         if (!pv && ($urandom_range(0, 9) < 6)) begin
            pv = 1;
            pa = 6'($urandom_range(0, 15));
            pd = $urandom;
            pf = 5'($urandom);
         end
         cycle(pv, pa, pd, pf, ($urandom_range(0, 1) == 1),
               {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                6'($urandom_range(0, 15))},
               3'($urandom), acc);
         if (acc) pv = 0;
      end
      for (int i = 0; i < 4; i++) cycle(0, 6'd0, 32'h0, 5'h0, 0, '0, '0, acc);
      @(negedge clk);
      #4;
      chk("drained", 64'(sb.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
